// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mdu_pkg
//  Purpose  : Shared definitions for the multiply/divide unit. It holds the
//             MDUOp encodings, the operation type, the default latencies, the
//             control FSM state type and small helpers that classify ops.
//  Revision : 1.0  initial release
// ============================================================================
package mdu_pkg;

   // 3-bit operation code presented on MDUOp
   typedef logic [2:0] mdu_op_t;

   localparam mdu_op_t C_OP_NONE  = 3'd0;
   localparam mdu_op_t C_OP_MULT  = 3'd1;
   localparam mdu_op_t C_OP_MULTU = 3'd2;
   localparam mdu_op_t C_OP_DIV   = 3'd3;
   localparam mdu_op_t C_OP_DIVU  = 3'd4;
   localparam mdu_op_t C_OP_MTHI  = 3'd5;
   localparam mdu_op_t C_OP_MTLO  = 3'd6;
   localparam mdu_op_t C_OP_RSVD  = 3'd7;   // behaves exactly like none

   localparam int C_DEF_MULT_CYCLES = 5;
   localparam int C_DEF_DIV_CYCLES  = 10;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } mdu_state_t;

   function automatic logic is_mul_op(input mdu_op_t op);
      return (op == C_OP_MULT) || (op == C_OP_MULTU);
   endfunction

   function automatic logic is_div_op(input mdu_op_t op);
      return (op == C_OP_DIV) || (op == C_OP_DIVU);
   endfunction

endpackage : mdu_pkg
`default_nettype wire

// File: rtl/mdu_arith.sv
`default_nettype none
// ============================================================================
//  Module   : mdu_arith
//  Purpose  : Combinational datapath of the multiply/divide unit. Produces
//             the 2*WIDTH pending {hi, lo} value for the selected operation
//             plus a flag for a division whose divisor is zero.
//  Ports    : i_a, i_b        operands (dividend / divisor for division)
//             i_op            operation code (mdu_pkg encodings)
//             o_result        {hi, lo}: product, or {remainder, quotient}
//             o_div_by_zero   division op with i_b == 0
//  Revision : 1.0  initial release
// ============================================================================
module mdu_arith
   import mdu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0]   i_a,
   input  logic [WIDTH-1:0]   i_b,
   input  logic [2:0]         i_op,
   output logic [2*WIDTH-1:0] o_result,
   output logic               o_div_by_zero
);

   logic signed [2*WIDTH-1:0] w_a_sx;
   logic signed [2*WIDTH-1:0] w_b_sx;
   logic signed [2*WIDTH-1:0] w_prod_s;
   logic        [2*WIDTH-1:0] w_prod_u;

   logic                      w_div_signed;
   logic                      w_a_neg;
   logic                      w_b_neg;
   logic                      w_b_zero;
   logic        [WIDTH-1:0]   w_mag_a;
   logic        [WIDTH-1:0]   w_mag_b;
   logic        [WIDTH-1:0]   w_den;
   logic        [WIDTH-1:0]   w_quo;
   logic        [WIDTH-1:0]   w_rem;
   logic        [WIDTH-1:0]   w_quo_out;
   logic        [WIDTH-1:0]   w_rem_out;

   // Sign/zero extension to the full product width makes a plain 2*WIDTH
   // multiply give the exact product in both modes.
   assign w_a_sx   = {{WIDTH{i_a[WIDTH-1]}}, i_a};
   assign w_b_sx   = {{WIDTH{i_b[WIDTH-1]}}, i_b};
   assign w_prod_s = w_a_sx * w_b_sx;
   assign w_prod_u = {{WIDTH{1'b0}}, i_a} * {{WIDTH{1'b0}}, i_b};

   // Signed division is done on magnitudes, then the signs are restored:
   // the quotient truncates toward zero and the remainder follows the
   // dividend. The most-negative / -1 case falls out naturally: its
   // magnitude wraps back to the most-negative value with remainder 0.
   assign w_div_signed = (i_op == C_OP_DIV);
   assign w_a_neg      = w_div_signed & i_a[WIDTH-1];
   assign w_b_neg      = w_div_signed & i_b[WIDTH-1];
   assign w_b_zero     = (i_b == '0);
   assign w_mag_a      = w_a_neg ? (~i_a + 1'b1) : i_a;
   assign w_mag_b      = w_b_neg ? (~i_b + 1'b1) : i_b;
   // Divide by one when the divisor is zero so the datapath stays defined;
   // the commit logic discards that result anyway.
   assign w_den        = w_b_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : w_mag_b;
   assign w_quo        = w_mag_a / w_den;
   assign w_rem        = w_mag_a % w_den;
   assign w_quo_out    = (w_a_neg ^ w_b_neg) ? (~w_quo + 1'b1) : w_quo;
   assign w_rem_out    = w_a_neg ? (~w_rem + 1'b1) : w_rem;

   always_comb begin
      o_result      = '0;
      o_div_by_zero = 1'b0;
      case (i_op)
         C_OP_MULT:  o_result = w_prod_s;
         C_OP_MULTU: o_result = w_prod_u;
         C_OP_DIV,
         C_OP_DIVU: begin
            o_result      = {w_rem_out, w_quo_out};
            o_div_by_zero = w_b_zero;
         end
         default: ;
      endcase
   end

endmodule : mdu_arith
`default_nettype wire

// File: rtl/mdu.sv
`default_nettype none
// ============================================================================
//  Module   : mdu
//  Purpose  : Multi-cycle multiply/divide unit with private HI/LO registers.
//             Results are computed on the accepting edge into a pending
//             register and copied to HI/LO only when busy falls, so the
//             architectural outputs never show in-flight values.
//  Ports    : clk, reset      clock, synchronous active-high reset
//             start, MDUOp    launch request and operation code
//             A, B            operands (dividend / divisor for division)
//             busy            multi-cycle operation in flight
//             hi, lo          architectural HI / LO registers
//             div_by_zero     sticky, set by a division with B == 0
//  Revision : 1.0  initial release
// ============================================================================
module mdu
   import mdu_pkg::*;
#(
   parameter int WIDTH       = 32,
   parameter int MULT_CYCLES = C_DEF_MULT_CYCLES,
   parameter int DIV_CYCLES  = C_DEF_DIV_CYCLES
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       MDUOp,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             div_by_zero
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

   localparam logic [CNT_W-1:0] C_MULT_LOAD = CNT_W'(MULT_CYCLES);
   localparam logic [CNT_W-1:0] C_DIV_LOAD  = CNT_W'(DIV_CYCLES);
   localparam logic [CNT_W-1:0] C_CNT_ONE   = CNT_W'(1);

   mdu_state_t           state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [2*WIDTH-1:0]   pend_q, pend_d;
   logic                 pend_dbz_q, pend_dbz_d;
   logic [WIDTH-1:0]     hi_q, hi_d;
   logic [WIDTH-1:0]     lo_q, lo_d;
   logic                 dbz_q, dbz_d;

   logic [2*WIDTH-1:0]   arith_result;
   logic                 arith_dbz;
   logic                 accept;

   mdu_arith #(
      .WIDTH (WIDTH)
   ) u_arith (
      .i_a           (A),
      .i_b           (B),
      .i_op          (MDUOp),
      .o_result      (arith_result),
      .o_div_by_zero (arith_dbz)
   );

   // A start seen while busy is dropped, not queued.
   assign accept = start && (state_q == ST_IDLE);

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      pend_d     = pend_q;
      pend_dbz_d = pend_dbz_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      dbz_d      = dbz_q;

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (is_mul_op(MDUOp) || is_div_op(MDUOp)) begin
                  state_d    = ST_BUSY;
                  cnt_d      = is_mul_op(MDUOp) ? C_MULT_LOAD : C_DIV_LOAD;
                  pend_d     = arith_result;
                  pend_dbz_d = arith_dbz;
               end else if (MDUOp == C_OP_MTHI) begin
                  hi_d = A;
               end else if (MDUOp == C_OP_MTLO) begin
                  lo_d = A;
               end
            end
         end
         ST_BUSY: begin
            if (cnt_q == C_CNT_ONE) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
               // A zero-divisor division keeps the old HI/LO and only
               // raises the sticky flag.
               if (pend_dbz_q) begin
                  dbz_d = 1'b1;
               end else begin
                  hi_d = pend_q[2*WIDTH-1:WIDTH];
                  lo_d = pend_q[WIDTH-1:0];
               end
            end else begin
               cnt_d = cnt_q - C_CNT_ONE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         pend_q     <= '0;
         pend_dbz_q <= 1'b0;
         hi_q       <= '0;
         lo_q       <= '0;
         dbz_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         pend_q     <= pend_d;
         pend_dbz_q <= pend_dbz_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
         dbz_q      <= dbz_d;
      end
   end

   assign busy        = (state_q == ST_BUSY);
   assign hi          = hi_q;
   assign lo          = lo_q;
   assign div_by_zero = dbz_q;

endmodule : mdu
`default_nettype wire
